stopwatch_control: RTL and testbench
====================================

# stopwatch_control

Front-end control stage for the stopwatch, placed between the three raw push-buttons and `time_counter`. It synchronises and debounces `button_start`, `button_stop` and `button_reset`, and turns each debounced press into a single-cycle event. A three-state run/pause/idle machine then produces the `hold_count` level and a one-cycle `clear_count` pulse that drive `time_counter` directly, so the counter no longer sees bouncing raw buttons.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive cycles a synchronised input must differ from its debounced level before that level flips (10 ms at 50 MHz); minimum 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: width of each debounce counter; derived, never overridden.

Ports:
- `clock` input 1: single system clock; every flop is on its rising edge.
- `reset` input 1: synchronous, active-high system reset.
- `button_start` input 1: raw, asynchronous, active-high start button.
- `button_stop` input 1: raw, asynchronous, active-high stop button.
- `button_reset` input 1: raw, asynchronous, active-high stopwatch-clear button.
- `hold_count` output 1: 1 = counter frozen; connects to `time_counter.hold_count`.
- `clear_count` output 1: one-cycle pulse that zeroes the counter; ORed with `reset` at the top level into `time_counter.reset`.
- `running` output 1: 1 only in state RUNNING; equals `~hold_count`.
- `state` output 2: FSM state, IDLE=2'b00, RUNNING=2'b01, PAUSED=2'b10; 2'b11 is never produced.

## Operation
- Per button, three independent identical lanes:
  - 2-flop synchroniser: `sync1` then `sync2`.
  - Debounce: on each edge where `sync2 != deb`, if `cnt == DEBOUNCE_CYCLES-1` then `deb <= sync2` and `cnt <= 0`, else `cnt <= cnt+1`. On each edge where `sync2 == deb`, `cnt <= 0`.
  - Edge detect: `deb_d <= deb`; `press = deb & ~deb_d`, combinational. A held button gives exactly one press. Releases give none.
- FSM, evaluated on every edge using the press signals. Priority is reset press > stop press > start press when several coincide in one cycle:
  - IDLE: start → RUNNING. Reset press → stay in IDLE and pulse `clear_count`. Stop is ignored.
  - RUNNING: stop → PAUSED. Reset press → IDLE and pulse `clear_count`. Start is ignored.
  - PAUSED: start → RUNNING. Reset press → IDLE and pulse `clear_count`. Stop is ignored.
- Outputs are registered:
  - `clear_count` is high for exactly the one cycle following the edge that consumed a reset press.
  - `hold_count = (next_state != RUNNING)`.
- A reset press together with start in IDLE leaves the block in IDLE; start is discarded, not queued.
- Counter arithmetic is unsigned `CNT_W` bits. `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so it never wraps.

## Timing
- After `reset` high on an edge, all of the following hold:
  - `state`=IDLE, `hold_count`=1, `running`=0, `clear_count`=0.
  - All `sync1`/`sync2`/`deb`/`deb_d` are 0 and all `cnt` are 0.
- `reset` asserted mid-debounce or mid-press abandons all progress. A button still held when `reset` deasserts is treated as a new press and must debounce fully again.
- Latency: let raw input high be first sampled into `sync1` at edge E and held stable.
  - `deb` rises at edge E+1+DEBOUNCE_CYCLES.
  - `press` is high during the following cycle.
  - `state`, `hold_count`, `running` and `clear_count` update at edge E+2+DEBOUNCE_CYCLES.
- Any excursion of `sync2` shorter than DEBOUNCE_CYCLES cycles produces no change in `deb`.
- A bounce back to the old level resets `cnt`, so the stability window restarts.
- Release is debounced the same way. A new press is recognised only after the release has itself been debounced.

## Test plan
Bench uses DEBOUNCE_CYCLES=4.
- Reset then idle: assert `reset` for 2 cycles with buttons low → `state`=00, `hold_count`=1, `running`=0, `clear_count`=0 held for 50 cycles.
- Clean start: raise `button_start` at edge E and hold 20 cycles → `state`=01, `hold_count`=0 exactly at edge E+6. There is only one transition, and later stop/start presses behave per the FSM.
- Bounce rejection: toggle `button_stop` in RUNNING with pulses of 1, 2 and 3 cycles separated by 1-cycle lows → `state` stays 01. Then hold it 10 cycles → `state`=10 at the 6th edge after the stable rise.
- Pause/resume/clear: start → RUNNING, stop → PAUSED, start → RUNNING, reset button → IDLE. Require `clear_count` high for exactly one cycle, coincident with `state` becoming 00.
- Simultaneous presses: in RUNNING, raise `button_stop` and `button_reset` on the same edge → `state`=00 with one `clear_count` pulse, never 10. In IDLE, start+reset together → stays 00 with one `clear_count` pulse.
- Reset mid-operation: hold `button_start` and assert `reset` 2 cycles before `deb` would rise → remain IDLE. After `reset` deasserts with the button still held, RUNNING is entered 6 edges later.

Source files
------------

// File: rtl/stopwatch_control_if.sv
// Button and control signals between the stopwatch front-end and its surroundings.
// The master side drives the raw buttons; the slave side is stopwatch_control.
interface stopwatch_control_if;
   logic       button_start;
   logic       button_stop;
   logic       button_reset;
   logic       hold_count;
   logic       clear_count;
   logic       running;
   logic [1:0] state;

   modport master (
      output button_start, button_stop, button_reset,
      input  hold_count, clear_count, running, state
   );

   modport slave (
      input  button_start, button_stop, button_reset,
      output hold_count, clear_count, running, state
   );
endinterface

// File: rtl/stopwatch_control.sv
// Synchronises, debounces and edge-detects three raw buttons, then runs the
// idle/running/paused machine that drives time_counter's hold and clear inputs.
module stopwatch_control #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic               clock,
   input  logic               reset,
   stopwatch_control_if.slave bus
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RUNNING = 2'b01,
      PAUSED  = 2'b10
   } state_t;

   // Lane order: bit 0 = start, bit 1 = stop, bit 2 = reset button.
   logic [2:0]       raw;
   logic [2:0]       sync1;
   logic [2:0]       sync2;
   logic [2:0]       deb;
   logic [2:0]       deb_d;
   logic [2:0]       press;
   logic [CNT_W-1:0] cnt [3];

   state_t state_q;
   state_t state_d;
   logic   clear_d;
   logic   clear_q;
   logic   hold_q;

   assign raw   = {bus.button_reset, bus.button_stop, bus.button_start};
   assign press = deb & ~deb_d;

   // Any bounce back to the debounced level restarts the stability window.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_d <= '0;
         for (int i = 0; i < 3; i++) cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         deb_d <= deb;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               deb[i] <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Reset press dominates; stop only matters while running, start only otherwise.
   always_comb begin
      state_d = state_q;
      clear_d = 1'b0;
      if (press[2]) begin
         state_d = IDLE;
         clear_d = 1'b1;
      end else begin
         case (state_q)
            IDLE:    if (press[0]) state_d = RUNNING;
            RUNNING: if (press[1]) state_d = PAUSED;
            PAUSED:  if (press[0]) state_d = RUNNING;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         hold_q  <= 1'b1;
         clear_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= (state_d != RUNNING);
         clear_q <= clear_d;
      end
   end

   assign bus.state       = state_q;
   assign bus.hold_count  = hold_q;
   assign bus.running     = ~hold_q;
   assign bus.clear_count = clear_q;
endmodule

// File: tb/tb_stopwatch_control.sv
// Self-checking bench for stopwatch_control with a short debounce window: a
// sliding-window reference model feeds an expected queue checked every cycle.
module tb_stopwatch_control;
   localparam int DEB = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;

   stopwatch_control_if bus ();

   stopwatch_control #(.DEBOUNCE_CYCLES(DEB)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int         n_vec = 0;
   int         n_bad = 0;
   string      phase = "init";
   logic [4:0] exp_q [$];

   // Reference model: raw-sample history per button, debounced level, pending press, FSM.
   logic [DEB:0] hist [3];
   logic [2:0]   m_deb;
   logic [2:0]   m_press;
   logic [1:0]   m_state;
   logic         m_clear;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Level flips once the D raw samples preceding the sync2 stage all differ from it.
   task automatic model_step(input logic rst, input logic [2:0] raw);
      logic all_diff;
      if (rst) begin
         for (int b = 0; b < 3; b++) hist[b] = '0;
         m_deb   = '0;
         m_press = '0;
         m_state = 2'b00;
         m_clear = 1'b0;
      end else begin
         m_clear = 1'b0;
         if (m_press[2]) begin
            m_state = 2'b00;
            m_clear = 1'b1;
         end else if (m_press[1] && m_state == 2'b01) begin
            m_state = 2'b10;
         end else if (m_press[0] && m_state != 2'b01) begin
            m_state = 2'b01;
         end
         m_press = '0;
         for (int b = 0; b < 3; b++) begin
            all_diff = 1'b1;
            for (int i = 1; i <= DEB; i++) if (hist[b][i] == m_deb[b]) all_diff = 1'b0;
            if (all_diff) begin
               m_deb[b]   = ~m_deb[b];
               m_press[b] = m_deb[b];
            end
            hist[b] = {hist[b][DEB-1:0], raw[b]};
         end
      end
   endtask

   // One clock: drive at the falling edge, check just after the rising edge.
   task automatic tick(input logic rst, input logic [2:0] raw);
      logic [4:0] got;
      reset            = rst;
      bus.button_start = raw[0];
      bus.button_stop  = raw[1];
      bus.button_reset = raw[2];
      model_step(rst, raw);
      exp_q.push_back({m_state, (m_state != 2'b01), (m_state == 2'b01), m_clear});
      @(posedge clock);
      #1;
      got = {bus.state, bus.hold_count, bus.running, bus.clear_count};
      check(phase, 32'(got), 32'(exp_q.pop_front()));
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 3'b000);
   endtask

   task automatic press_hold(input logic [2:0] raw, input int n);
      for (int i = 0; i < n; i++) tick(1'b0, raw);
      idle(10);
   endtask

   initial begin
      int lat;
      int n_clr;
      int trans;
      logic [1:0] prev;
      logic saw_bad;
      logic clr_idle;

      bus.button_start = 1'b0;
      bus.button_stop  = 1'b0;
      bus.button_reset = 1'b0;
      @(negedge clock);

      phase = "reset";
      tick(1'b1, 3'b000);
      tick(1'b1, 3'b000);
      check("rst_state", 32'(bus.state), 32'd0);
      check("rst_hold", 32'(bus.hold_count), 32'd1);
      check("rst_running", 32'(bus.running), 32'd0);
      check("rst_clear", 32'(bus.clear_count), 32'd0);
      phase = "idle";
      idle(50);

      phase = "clean_start";
      lat = -1; trans = 0; prev = bus.state;
      for (int i = 0; i < 20; i++) begin
         tick(1'b0, 3'b001);
         if (lat < 0 && bus.state == 2'b01) lat = i;
         if (bus.state != prev) trans++;
         prev = bus.state;
      end
      check("start_latency", 32'(lat), 32'd6);
      check("start_transitions", 32'(trans), 32'd1);
      idle(10);
      press_hold(3'b001, 10);
      check("start_ignored_running", 32'(bus.state), 32'd1);

      phase = "bounce";
      tick(1'b0, 3'b010); tick(1'b0, 3'b000);
      tick(1'b0, 3'b010); tick(1'b0, 3'b010); tick(1'b0, 3'b000);
      tick(1'b0, 3'b010); tick(1'b0, 3'b010); tick(1'b0, 3'b010); tick(1'b0, 3'b000);
      idle(6);
      check("bounce_rejected", 32'(bus.state), 32'd1);
      lat = -1;
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, 3'b010);
         if (lat < 0 && bus.state == 2'b10) lat = i;
      end
      check("stop_latency", 32'(lat), 32'd6);
      idle(10);

      phase = "pause_resume";
      press_hold(3'b001, 8);
      check("resume", 32'(bus.state), 32'd1);
      press_hold(3'b010, 8);
      check("pause", 32'(bus.state), 32'd2);
      press_hold(3'b001, 8);
      check("resume2", 32'(bus.state), 32'd1);
      n_clr = 0; clr_idle = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick(1'b0, 3'b100);
         if (bus.clear_count) begin
            n_clr++;
            if (bus.state != 2'b00) clr_idle = 1'b0;
         end
      end
      check("clear_width", 32'(n_clr), 32'd1);
      check("clear_with_idle", 32'(clr_idle), 32'd1);
      idle(10);

      phase = "simultaneous";
      press_hold(3'b001, 8);
      n_clr = 0; saw_bad = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick(1'b0, 3'b110);
         if (bus.clear_count) n_clr++;
         if (bus.state == 2'b10) saw_bad = 1'b1;
      end
      check("stop_reset_clear", 32'(n_clr), 32'd1);
      check("stop_reset_never_paused", 32'(saw_bad), 32'd0);
      check("stop_reset_state", 32'(bus.state), 32'd0);
      idle(10);
      n_clr = 0; saw_bad = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick(1'b0, 3'b101);
         if (bus.clear_count) n_clr++;
         if (bus.state != 2'b00) saw_bad = 1'b1;
      end
      check("start_reset_clear", 32'(n_clr), 32'd1);
      check("start_reset_stays_idle", 32'(saw_bad), 32'd0);
      idle(10);

      phase = "reset_mid";
      tick(1'b0, 3'b001); tick(1'b0, 3'b001); tick(1'b0, 3'b001);
      tick(1'b1, 3'b001); tick(1'b1, 3'b001);
      check("mid_reset_idle", 32'(bus.state), 32'd0);
      lat = -1;
      for (int i = 0; i < 12; i++) begin
         tick(1'b0, 3'b001);
         if (lat < 0 && bus.state == 2'b01) lat = i;
      end
      check("post_reset_latency", 32'(lat), 32'd6);
      idle(10);

      phase = "random";
      for (int k = 0; k < 150; k++) begin
         logic [2:0] r;
         int len;
         r   = 3'($urandom_range(0, 7));
         len = $urandom_range(1, 8);
         for (int i = 0; i < len; i++) tick(($urandom_range(0, 99) == 0), r);
      end
      idle(12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
